instruction_fetch_unit: RTL
===========================

# instruction_fetch_unit

Fetch stage of the single-cycle ARMv8 datapath. It owns the program counter, drives the word address into the combinational instruction memory, and captures the returned 32-bit instruction and its PC into a registered fetch output. Decode consumes that output through a valid/ready handshake. Branch and CBZ resolution redirect the stream through a single redirect port.

## Interface
- `END_ADDR`, default 64'h04C: first address that is never fetched. Reaching it halts fetch.
- `CLK` input 1: the only clock. All state updates on the rising edge.
- `Reset` input 1: synchronous, active-high.
- `StartPC` input 64: PC loaded while `Reset` is high.
- `InstAddr` output 64: address to instruction memory. Equals the PC register (combinational from a register).
- `InstData` input 32: instruction returned combinationally for `InstAddr`.
- `RedirectValid` input 1: taken branch, B or CBZ, from downstream.
- `RedirectPC` input 64: branch target. Bits [1:0] are ignored and forced to 0.
- `OutReady` input 1: decode accepts the current output this cycle.
- `InstValid` output 1: `Instruction`/`InstPC` hold a valid fetched instruction.
- `Instruction` output 32: fetched instruction.
- `InstPC` output 64: address `Instruction` was fetched from.
- `Halted` output 1: high while in state HALT.
- `FetchCount` output 32: count of instructions accepted by decode (see Configuration).

## Operation
- States: RUN, HOLD, HALT. Reset state is RUN.
- **Reset**
  - PC <= `StartPC & ~3`.
  - `InstValid`=0, `Instruction`=0, `InstPC`=0, `Halted`=0, `FetchCount`=0.
  - Reset overrides every other input.
- **Capture opportunity:** a cycle where `InstValid`=0, or `InstValid`=1 and `OutReady`=1.
- **RUN**, no redirect, at a capture opportunity:
  - If PC == `END_ADDR`: nothing is captured; `InstValid`<=0; go to HALT.
  - Otherwise: `Instruction`<=`InstData`, `InstPC`<=PC, `InstValid`<=1, PC<=PC+4.
- **RUN -> HOLD** when `InstValid`=1 and `OutReady`=0.
- **HOLD**
  - PC, `Instruction`, `InstPC` and `InstValid` are frozen.
  - Returns to RUN in the first cycle with `OutReady`=1. The capture in that cycle proceeds as in RUN, so throughput is unbroken.
- **HALT**
  - PC is frozen and nothing is captured. `InstValid` is already 0 on entry.
  - Leaves HALT only by redirect or reset.
- **Redirect** (`RedirectValid`=1, any state, priority below Reset):
  - PC <= `RedirectPC & ~3`.
  - `InstValid`<=0. Any held instruction is discarded and not counted.
  - No capture in that cycle. Next state is RUN.
- **Arithmetic**
  - PC+4 is modulo 2^64; 0xFFFF_FFFF_FFFF_FFFC wraps to 0.
  - The `END_ADDR` compare is exact equality on all 64 bits, checked before capture.
- **Simultaneous events**
  - Redirect together with `OutReady`=1 and `InstValid`=1: the current output counts as accepted (`FetchCount` increments), then the flush happens.
  - Redirect to `END_ADDR`: RUN is entered, then HALT on the next cycle with no capture.

## Timing
- Latency: an instruction at PC appears on `Instruction` one cycle after PC is driven on `InstAddr`.
- Steady state: one instruction per cycle while `OutReady`=1.
- Redirect penalty: exactly one bubble. `InstValid`=0 in the cycle after the redirect; the target instruction is valid the cycle after that.
- Handshake: a transfer occurs on an edge where `InstValid`=1 and `OutReady`=1. Outputs are stable while `InstValid`=1 and `OutReady`=0.
- `InstData` is sampled only at capture; X on unmapped addresses is not propagated outside capture.

## Configuration
- Macro `FETCH_PERF_CNT_EN`.
- **Defined:**
  - `FETCH_PERF_CNT_EN` adds a 32-bit counter that increments on every handshake transfer.
  - The counter wraps at 2^32 and resets to 0.
  - It is driven on `FetchCount`.
- **Undefined:**
  - The counter is not built and `FetchCount` is tied to 0.
  - Port list is unchanged.

## Test plan
- **Reset and streaming:** `StartPC`=0, memory image loaded, `OutReady`=1. Expect `InstValid`=0 in the cycle after reset, then (PC,instruction) pairs (0x000, AA1F03F4), (0x004, F8400289), (0x008, F840828A) on consecutive cycles.
- **Stall:** drop `OutReady` for 3 cycles while `InstPC`=0x008. Expect `Instruction`=F840828A held, `InstAddr`=0x00C frozen. On release expect (0x00C, F841028B) the next cycle, with no instruction lost or duplicated.
- **Redirect with flush:** while HOLD on 0x010, assert `RedirectValid` with `RedirectPC`=0x026. Expect the held instruction dropped and `FetchCount` unchanged, one bubble, then (0x024, 8B0901AD).
- **Halt and restart:** `END_ADDR`=0x04C, stream from 0x038. Expect the last valid output (0x048, F842828A), then `Halted`=1 and `InstAddr` stuck at 0x04C. Redirect to 0x038 and expect `Halted`=0, then (0x038, D2E24689).
- **Reset mid-operation:** assert `Reset` during HOLD with `StartPC`=0x03C. Expect all outputs at their reset values the next cycle, then (0x03C, F843028B).
- **Counter:** with the macro defined, 5 transfers, 2 stall cycles and 1 flushed instruction give `FetchCount`=5. Without the macro, `FetchCount`=0 throughout.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory port, redirect port and decode handshake.
// No logic of its own; the fetch unit drives through `master`, and decode/imem/branch-resolve use `slave`.
// Backpressure is carried by OutReady; InstValid/Instruction/InstPC hold while it is low.
interface instruction_fetch_unit_if;
   logic [63:0] InstAddr;
   logic [31:0] InstData;
   logic        RedirectValid;
   logic [63:0] RedirectPC;
   logic        OutReady;
   logic        InstValid;
   logic [31:0] Instruction;
   logic [63:0] InstPC;
   logic        Halted;
   logic [31:0] FetchCount;

   modport master (
      output InstAddr, InstValid, Instruction, InstPC, Halted, FetchCount,
      input  InstData, RedirectValid, RedirectPC, OutReady
   );

   modport slave (
      input  InstAddr, InstValid, Instruction, InstPC, Halted, FetchCount,
      output InstData, RedirectValid, RedirectPC, OutReady
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads combinational imem, registers (PC, instruction) for decode.
// Latency 1 cycle from InstAddr to Instruction; one instruction per cycle with OutReady high.
// Backpressure: OutReady low freezes PC and output (HOLD). Macro FETCH_PERF_CNT_EN builds FetchCount.
module instruction_fetch_unit #(
   parameter logic [63:0] END_ADDR = 64'h04C
) (
   input  logic                     CLK,
   input  logic                     Reset,
   input  logic [63:0]              StartPC,
   instruction_fetch_unit_if.master fetch
);

   typedef enum logic [1:0] {S_RUN, S_HOLD, S_HALT} state_t;

   state_t      r_state, w_state_nxt;
   logic [63:0] r_pc, w_pc_nxt;
   logic [63:0] r_inst_pc, w_inst_pc_nxt;
   logic [31:0] r_inst, w_inst_nxt;
   logic        r_vld, w_vld_nxt;
   logic        w_capture_opp;
   logic        w_at_end;

   // A capture is allowed when the output slot is empty or is being consumed this cycle.
   assign w_capture_opp = !r_vld || fetch.OutReady;
   assign w_at_end      = (r_pc == END_ADDR);

   // Next-state and datapath select; redirect outranks everything but reset.
   always_comb begin
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc;
      w_vld_nxt     = r_vld;
      w_inst_nxt    = r_inst;
      w_inst_pc_nxt = r_inst_pc;
      if (fetch.RedirectValid) begin
         w_pc_nxt    = fetch.RedirectPC & ~64'd3;
         w_vld_nxt   = 1'b0;
         w_state_nxt = S_RUN;
      end else begin
         case (r_state)
            // HOLD always has a valid output, so its capture opportunity is just OutReady;
            // the release cycle captures exactly like RUN to keep throughput unbroken.
            S_RUN, S_HOLD: begin
               if (w_capture_opp) begin
                  if (w_at_end) begin
                     w_vld_nxt   = 1'b0;
                     w_state_nxt = S_HALT;
                  end else begin
                     w_inst_nxt    = fetch.InstData;
                     w_inst_pc_nxt = r_pc;
                     w_vld_nxt     = 1'b1;
                     w_pc_nxt      = r_pc + 64'd4;
                     w_state_nxt   = S_RUN;
                  end
               end else begin
                  w_state_nxt = S_HOLD;
               end
            end
            S_HALT: begin
               w_state_nxt = S_HALT;
            end
            default: begin
               w_state_nxt = S_RUN;
            end
         endcase
      end
   end

   // State, PC and output registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state   <= S_RUN;
         r_pc      <= StartPC & ~64'd3;
         r_vld     <= 1'b0;
         r_inst    <= 32'd0;
         r_inst_pc <= 64'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_vld     <= w_vld_nxt;
         r_inst    <= w_inst_nxt;
         r_inst_pc <= w_inst_pc_nxt;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_fetch_cnt;
   logic        w_xfer;

   // A transfer still counts when a redirect flushes the stage in the same cycle.
   assign w_xfer = r_vld && fetch.OutReady;

   // Accepted-instruction counter, wraps at 2^32.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_fetch_cnt <= 32'd0;
      end else if (w_xfer) begin
         r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
   end

   assign fetch.FetchCount = r_fetch_cnt;
`else
   assign fetch.FetchCount = 32'd0;
`endif

   assign fetch.InstAddr    = r_pc;
   assign fetch.InstValid   = r_vld;
   assign fetch.Instruction = r_inst;
   assign fetch.InstPC      = r_inst_pc;
   assign fetch.Halted      = (r_state == S_HALT);

endmodule
